// File: rtl/hamming_enc_ctrl.sv
// Byte-to-two-codeword controller that time-shares one external Hamming(7,4) encoder.
// Optional macro HAM_CTRL_CNT_EN adds a 16-bit completed-frame counter output (frame_cnt).
module hamming_enc_ctrl #(
    parameter int unsigned ENC_LAT = 1
) (
    input  logic         clk_enc,
    input  logic         rst_enc,
    input  logic         in_valid,
    input  logic [8:1]   in_data,
    output logic         in_ready,
    output logic [4:1]   enc_data,
    input  logic [7:1]   codeword_in,
    output logic         out_valid,
    output logic [14:1]  out_code,
    input  logic         out_ready,
    output logic         busy
`ifdef HAM_CTRL_CNT_EN
    ,
    output logic [16:1]  frame_cnt
`endif
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] LAT = CNT_W'(ENC_LAT);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_LO = 2'd1;
    localparam logic [1:0] WAIT_HI = 2'd2;
    localparam logic [1:0] OUT     = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] wcnt;
    logic [CNT_W-1:0] wcnt_nxt;
    logic [4:1]       hi_nib;
    logic [4:1]       hi_nib_nxt;
    logic [4:1]       enc_data_nxt;
    logic [14:1]      out_code_nxt;
    logic             xfer;

    assign xfer = out_valid & out_ready;

    // Next-state: each nibble waits ENC_LAT+1 edges for the encoder result.
    always_comb begin
        state_nxt    = state;
        wcnt_nxt     = wcnt;
        hi_nib_nxt   = hi_nib;
        enc_data_nxt = enc_data;
        out_code_nxt = out_code;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    enc_data_nxt = in_data[4:1];
                    hi_nib_nxt   = in_data[8:5];
                    wcnt_nxt     = '0;
                    state_nxt    = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (wcnt == LAT) begin
                    out_code_nxt[7:1] = codeword_in;
                    enc_data_nxt      = hi_nib;
                    wcnt_nxt          = '0;
                    state_nxt         = WAIT_HI;
                end else begin
                    wcnt_nxt = wcnt + CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (wcnt == LAT) begin
                    out_code_nxt[14:8] = codeword_in;
                    wcnt_nxt           = '0;
                    state_nxt          = OUT;
                end else begin
                    wcnt_nxt = wcnt + CNT_W'(1);
                end
            end
            OUT: begin
                if (xfer) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; status flags follow the next state.
    always_ff @(posedge clk_enc or posedge rst_enc) begin
        if (rst_enc) begin
            state     <= IDLE;
            wcnt      <= '0;
            hi_nib    <= '0;
            enc_data  <= '0;
            out_code  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_nxt;
            wcnt      <= wcnt_nxt;
            hi_nib    <= hi_nib_nxt;
            enc_data  <= enc_data_nxt;
            out_code  <= out_code_nxt;
            out_valid <= (state_nxt == OUT);
            busy      <= (state_nxt != IDLE);
            in_ready  <= (state_nxt == IDLE);
        end
    end

`ifdef HAM_CTRL_CNT_EN
    // Completed output handshakes, wrapping at 16 bits.
    always_ff @(posedge clk_enc or posedge rst_enc) begin
        if (rst_enc) begin
            frame_cnt <= '0;
        end else if (xfer) begin
            frame_cnt <= frame_cnt + 16'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hamming_enc_ctrl.sv
// Self-checking bench for hamming_enc_ctrl: two instances (ENC_LAT=1 and 3), each with
// a behavioural encoder of matching latency, checked against a byte-level reference.
module tb_hamming_enc_ctrl;

    logic        clk_enc = 1'b0;
    logic        rst_enc = 1'b0;
    logic        in_valid_v [2];
    logic [8:1]  in_data_v  [2];
    logic        out_ready_v[2];

    logic        in_ready0, in_ready1;
    logic [4:1]  enc_data0, enc_data1;
    logic [7:1]  cw0, cw1;
    logic        out_valid0, out_valid1;
    logic [14:1] out_code0, out_code1;
    logic        busy0, busy1;
    logic [16:1] fcnt0, fcnt1;

    int n_checks = 0;
    int n_fail   = 0;
    int xfers [2];

    always #5 clk_enc = ~clk_enc;

`ifndef HAM_CTRL_CNT_EN
    assign fcnt0 = '0;
    assign fcnt1 = '0;
`endif

    hamming_enc_ctrl #(.ENC_LAT(1)) u_dut_lat1 (
        .clk_enc(clk_enc), .rst_enc(rst_enc),
        .in_valid(in_valid_v[0]), .in_data(in_data_v[0]), .in_ready(in_ready0),
        .enc_data(enc_data0), .codeword_in(cw0),
        .out_valid(out_valid0), .out_code(out_code0), .out_ready(out_ready_v[0]),
        .busy(busy0)
`ifdef HAM_CTRL_CNT_EN
        , .frame_cnt(fcnt0)
`endif
    );

    hamming_enc_ctrl #(.ENC_LAT(3)) u_dut_lat3 (
        .clk_enc(clk_enc), .rst_enc(rst_enc),
        .in_valid(in_valid_v[1]), .in_data(in_data_v[1]), .in_ready(in_ready1),
        .enc_data(enc_data1), .codeword_in(cw1),
        .out_valid(out_valid1), .out_code(out_code1), .out_ready(out_ready_v[1]),
        .busy(busy1)
`ifdef HAM_CTRL_CNT_EN
        , .frame_cnt(fcnt1)
`endif
    );

    // Hamming(7,4): data at positions 3,5,6,7; parity p covers every position with bit p set.
    function automatic logic [7:1] ham_ref(input logic [3:0] nib);
        logic [7:1] cw;
        logic       par;
        cw    = '0;
        cw[3] = nib[0];
        cw[5] = nib[1];
        cw[6] = nib[2];
        cw[7] = nib[3];
        for (int p = 1; p <= 4; p = p * 2) begin
            par = 1'b0;
            for (int i = 1; i <= 7; i++) begin
                if (((i & p) != 0) && (i != p)) par = par ^ cw[i];
            end
            cw[p] = par;
        end
        return cw;
    endfunction

    // External encoders: ENC_LAT pipeline stages each.
    always @(posedge clk_enc) cw0 <= ham_ref(enc_data0);

    logic [7:1] pipe3 [2];
    always @(posedge clk_enc) begin
        pipe3[0] <= ham_ref(enc_data1);
        pipe3[1] <= pipe3[0];
        cw1      <= pipe3[1];
    end

    typedef struct packed {
        logic        in_ready;
        logic        busy;
        logic        out_valid;
        logic [3:0]  enc;
        logic [13:0] code;
        logic [15:0] fcnt;
    } obs_t;

    function automatic obs_t obs(input int d);
        obs_t o;
        if (d == 0) o = '{in_ready0, busy0, out_valid0, enc_data0, out_code0, fcnt0};
        else        o = '{in_ready1, busy1, out_valid1, enc_data1, out_code1, fcnt1};
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input int d);
        obs_t o;
        o = obs(d);
        check("rst_in_ready", 32'(o.in_ready), 32'd0);
        check("rst_busy", 32'(o.busy), 32'd0);
        check("rst_out_valid", 32'(o.out_valid), 32'd0);
        check("rst_enc_data", 32'(o.enc), 32'd0);
        check("rst_out_code", 32'(o.code), 32'd0);
`ifdef HAM_CTRL_CNT_EN
        check("rst_frame_cnt", 32'(o.fcnt), 32'd0);
`endif
    endtask

    task automatic do_reset();
        in_valid_v[0] = 1'b0;
        in_valid_v[1] = 1'b0;
        rst_enc = 1'b1;
        #1;
        check_reset_vals(0);
        check_reset_vals(1);
        repeat (2) @(negedge clk_enc);
        rst_enc = 1'b0;
        xfers[0] = 0;
        xfers[1] = 0;
        @(negedge clk_enc);
        check("post_rst_in_ready0", 32'(obs(0).in_ready), 32'd1);
        check("post_rst_in_ready1", 32'(obs(1).in_ready), 32'd1);
    endtask

    // One byte through instance d; hold = cycles of backpressure once out_valid rises.
    task automatic run_byte(input int d, input int lat, input logic [7:0] b, input int hold);
        logic [13:0] exp;
        int          n;
        obs_t        o;
        exp = {ham_ref(b[7:4]), ham_ref(b[3:0])};
        n = 0;
        while (!obs(d).in_ready && n < 50) begin
            @(negedge clk_enc);
            n++;
        end
        check("wait_in_ready", 32'(obs(d).in_ready), 32'd1);
        out_ready_v[d] = (hold == 0);
        in_valid_v[d]  = 1'b1;
        in_data_v[d]   = b;
        @(negedge clk_enc);
        in_valid_v[d] = 1'b0;
        in_data_v[d]  = 8'($urandom);
        o = obs(d);
        check("lo_nibble", 32'(o.enc), 32'(b[3:0]));
        check("busy_after_accept", 32'(o.busy), 32'd1);
        check("in_ready_after_accept", 32'(o.in_ready), 32'd0);
        n = 0;
        while (!obs(d).out_valid && n < 40) begin
            @(negedge clk_enc);
            n++;
            if (n == lat + 1) check("hi_nibble", 32'(obs(d).enc), 32'(b[7:4]));
        end
        check("latency", 32'(n), 32'(2 * (lat + 1)));
        check("out_code", 32'(obs(d).code), 32'(exp));
        if (hold > 0) begin
            in_valid_v[d] = 1'b1;
            for (int k = 0; k < hold; k++) begin
                in_data_v[d] = 8'($urandom);
                @(negedge clk_enc);
                o = obs(d);
                check("bp_out_valid", 32'(o.out_valid), 32'd1);
                check("bp_out_code", 32'(o.code), 32'(exp));
                check("bp_in_ready", 32'(o.in_ready), 32'd0);
            end
            in_valid_v[d]  = 1'b0;
            out_ready_v[d] = 1'b1;
        end
        @(negedge clk_enc);
        xfers[d]++;
        o = obs(d);
        check("post_hs_out_valid", 32'(o.out_valid), 32'd0);
        check("post_hs_in_ready", 32'(o.in_ready), 32'd1);
        check("post_hs_busy", 32'(o.busy), 32'd0);
        check("enc_hold_idle", 32'(o.enc), 32'(b[7:4]));
`ifdef HAM_CTRL_CNT_EN
        check("frame_cnt", 32'(o.fcnt), 32'(16'(xfers[d])));
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        obs_t o;
        logic saw_valid;
        for (int d = 0; d < 2; d++) begin
            in_valid_v[d]  = 1'b0;
            in_data_v[d]   = '0;
            out_ready_v[d] = 1'b1;
        end
        @(negedge clk_enc);
        do_reset();

        // Idle after reset
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_enc);
            o = obs(0);
            check("idle_in_ready", 32'(o.in_ready), 32'd1);
            check("idle_busy", 32'(o.busy), 32'd0);
            check("idle_enc", 32'(o.enc), 32'd0);
            check("idle_out_valid", 32'(o.out_valid), 32'd0);
        end

        run_byte(0, 1, 8'hA5, 0);
        run_byte(0, 1, 8'h3C, 5);
        run_byte(1, 3, 8'h3C, 5);

        // Reset while the high nibble is in flight
        in_valid_v[0] = 1'b1;
        in_data_v[0]  = 8'h96;
        @(negedge clk_enc);
        in_valid_v[0] = 1'b0;
        repeat (2) @(negedge clk_enc);
        check("midrst_in_wait_hi", 32'(obs(0).enc), 32'h9);
        do_reset();
        saw_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk_enc);
            if (obs(0).out_valid) saw_valid = 1'b1;
        end
        check("midrst_no_valid", 32'(saw_valid), 32'd0);

        // Exhaustive stream on both latencies
        for (int b = 0; b < 256; b++) run_byte(0, 1, 8'(b), 0);
        for (int b = 0; b < 256; b++) run_byte(1, 3, 8'(b), 0);

        // Random bytes with random backpressure
        for (int k = 0; k < 20; k++) begin
            run_byte(0, 1, 8'($urandom), int'($urandom_range(0, 4)));
            run_byte(1, 3, 8'($urandom), int'($urandom_range(0, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
